// File: rtl/hdu_pkg.sv
// Hazard scoreboard shared definitions.
// Holds the default register-address width, the default load and pop
// latencies, and the 4-bit down-counter type used by every scoreboard entry.
package hdu_pkg;

    localparam int unsigned REG_ADDR_W_DEF    = 3;
    localparam int unsigned LOAD_LAT_DEF      = 1;
    localparam int unsigned POP_JMP_EXTRA_DEF = 1;
    localparam int unsigned CNT_W             = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Decrement that holds at zero.
    function automatic cnt_t cnt_dec(input cnt_t c);
        return (c == '0) ? '0 : c - cnt_t'(1);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: a forwarding counter and a jump counter for a
// single architectural register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : clears both counters at the next edge (pipeline flush)
//   issue       : a memory read targeting this register leaves EX
//   issue_pop   : that memory read is a pop (jump counter gets extra cycles)
//   fwd_cnt     : cycles until the value can be forwarded to an ordinary use
//   jmp_cnt     : cycles until the value can be consumed by a register jump
module sb_entry
    import hdu_pkg::*;
#(
    parameter int unsigned LOAD_LAT      = LOAD_LAT_DEF,
    parameter int unsigned POP_JMP_EXTRA = POP_JMP_EXTRA_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic issue,
    input  logic issue_pop,
    output cnt_t fwd_cnt,
    output cnt_t jmp_cnt
);

    localparam cnt_t FWD_INIT     = cnt_t'(LOAD_LAT - 1);
    localparam cnt_t JMP_POP_INIT = cnt_t'(LOAD_LAT - 1 + POP_JMP_EXTRA);

    cnt_t fwd_cnt_q, fwd_cnt_d;
    cnt_t jmp_cnt_q, jmp_cnt_d;

    // A new issue overrides the decrement of an older entry for the same register.
    always_comb begin
        fwd_cnt_d = cnt_dec(fwd_cnt_q);
        jmp_cnt_d = cnt_dec(jmp_cnt_q);
        if (clr) begin
            fwd_cnt_d = '0;
            jmp_cnt_d = '0;
        end else if (issue) begin
            fwd_cnt_d = FWD_INIT;
            jmp_cnt_d = issue_pop ? JMP_POP_INIT : FWD_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q <= '0;
            jmp_cnt_q <= '0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
            jmp_cnt_q <= jmp_cnt_d;
        end
    end

    assign fwd_cnt = fwd_cnt_q;
    assign jmp_cnt = jmp_cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / pop-jump hazard detection unit.
// Tracks, per register, how long until an in-flight load or pop result can be
// forwarded (ordinary use) or consumed by a register jump, and stalls decode
// while any used source operand is still pending.
//   clk, rst_n            : clock, asynchronous active-low reset
//   dec_valid/dec_rs/dec_rs_used/dec_jmp : decode-stage operand info
//   ex_valid/ex_mem_read/ex_pop/ex_rd     : execute-stage memory read info
//   flush                 : kills decode and all in-flight loads
//   stall, bubble_sel     : freeze IF/ID and insert a NOP into ID/EX
//   hazard_slot           : per-slot mask of operands causing the stall
//   stall_count           : saturating stall-cycle count
// Optional feature: define HDU_PERF_EN to build the stall_count register;
// otherwise stall_count is constant zero.
module hazard_scoreboard
    import hdu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W    = REG_ADDR_W_DEF,
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned LOAD_LAT      = LOAD_LAT_DEF,
    parameter int unsigned POP_JMP_EXTRA = POP_JMP_EXTRA_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dec_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs,
    input  logic [NUM_SRC-1:0]            dec_rs_used,
    input  logic                          dec_jmp,
    input  logic                          ex_valid,
    input  logic                          ex_mem_read,
    input  logic                          ex_pop,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          flush,
    output logic                          stall,
    output logic                          bubble_sel,
    output logic [NUM_SRC-1:0]            hazard_slot,
    output logic [15:0]                   stall_count
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

    cnt_t fwd_cnt [NUM_REGS];
    cnt_t jmp_cnt [NUM_REGS];

    logic               issue;
    logic [NUM_SRC-1:0] haz_raw;
    logic               dec_qual;

    assign issue = ex_valid & ex_mem_read & ~flush;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LOAD_LAT      (LOAD_LAT),
            .POP_JMP_EXTRA (POP_JMP_EXTRA)
        ) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (flush),
            .issue     (issue && (ex_rd == REG_ADDR_W'(r))),
            .issue_pop (ex_pop),
            .fwd_cnt   (fwd_cnt[r]),
            .jmp_cnt   (jmp_cnt[r])
        );
    end

    // The load leaving EX this cycle is not yet in any counter, so it is
    // matched directly against the decode operands.
    always_comb begin
        logic [REG_ADDR_W-1:0] rs;
        haz_raw = '0;
        rs      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rs         = dec_rs[i*REG_ADDR_W +: REG_ADDR_W];
            haz_raw[i] = dec_rs_used[i] &
                         ((issue & (ex_rd == rs)) | (fwd_cnt[rs] != '0));
        end
        rs = dec_rs[REG_ADDR_W-1:0];
        if (dec_jmp && ((issue && (ex_rd == rs)) || (jmp_cnt[rs] != '0))) begin
            haz_raw[0] = 1'b1;
        end
    end

    // rst_n is included so the outputs drop immediately on reset, even while
    // a load in EX would otherwise match combinationally.
    assign dec_qual    = dec_valid & ~flush & rst_n;
    assign hazard_slot = dec_qual ? haz_raw : '0;
    assign stall       = |hazard_slot;
    assign bubble_sel  = stall;

`ifdef HDU_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int AW  = 3;
    localparam int NS  = 2;
    localparam int NR  = 8;
    localparam int LL  = 3;
    localparam int PJE = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dec_valid = 1'b0;
    logic [NS*AW-1:0] dec_rs = '0;
    logic [NS-1:0]   dec_rs_used = '0;
    logic            dec_jmp = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_mem_read = 1'b0;
    logic            ex_pop = 1'b0;
    logic [AW-1:0]   ex_rd = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic            bubble_sel;
    logic [NS-1:0]   hazard_slot;
    logic [15:0]     stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDR_W    (AW),
        .NUM_SRC       (NS),
        .LOAD_LAT      (LL),
        .POP_JMP_EXTRA (PJE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_rs      (dec_rs),
        .dec_rs_used (dec_rs_used),
        .dec_jmp     (dec_jmp),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_pop      (ex_pop),
        .ex_rd       (ex_rd),
        .flush       (flush),
        .stall       (stall),
        .bubble_sel  (bubble_sel),
        .hazard_slot (hazard_slot),
        .stall_count (stall_count)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: each register remembers the last cycle number during
    // which its value is still unavailable to an ordinary use / a jump.
    int cyc = 0;
    int busy_f [NR];
    int busy_j [NR];
    int perf = 0;

    initial begin
        for (int r = 0; r < NR; r++) begin
            busy_f[r] = -1000;
            busy_j[r] = -1000;
        end
    end

    function automatic logic [NS-1:0] model_haz();
        logic [NS-1:0] h;
        logic iss;
        int rs;
        h   = '0;
        iss = ex_valid & ex_mem_read & ~flush;
        if (!(rst_n && dec_valid && !flush)) return '0;
        for (int i = 0; i < NS; i++) begin
            rs = int'(dec_rs[i*AW +: AW]);
            if (dec_rs_used[i] && ((iss && int'(ex_rd) == rs) || cyc <= busy_f[rs])) h[i] = 1'b1;
        end
        rs = int'(dec_rs[AW-1:0]);
        if (dec_jmp && ((iss && int'(ex_rd) == rs) || cyc <= busy_j[rs])) h[0] = 1'b1;
        return h;
    endfunction

    function automatic int exp_count();
`ifdef HDU_PERF_EN
        return perf;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                busy_f[r] = -1000;
                busy_j[r] = -1000;
            end
            perf = 0;
        end else begin
            if ((|model_haz()) && perf < 65535) perf++;
            if (flush) begin
                for (int r = 0; r < NR; r++) begin
                    busy_f[r] = cyc;
                    busy_j[r] = cyc;
                end
            end else if (ex_valid && ex_mem_read) begin
                busy_f[ex_rd] = cyc + LL - 1;
                busy_j[ex_rd] = cyc + LL - 1 + (ex_pop ? PJE : 0);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [NS-1:0] eh;
        eh = model_haz();
        check("stall", int'(stall), int'(|eh));
        check("bubble_sel", int'(bubble_sel), int'(|eh));
        check("hazard_slot", int'(hazard_slot), int'(eh));
        check("stall_count", int'(stall_count), exp_count());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        dec_valid = 0; dec_rs = '0; dec_rs_used = '0; dec_jmp = 0;
        ex_valid = 0; ex_mem_read = 0; ex_pop = 0; ex_rd = '0; flush = 0;
    endtask

    task automatic settle();
        set_idle();
        repeat (16) tick();
    endtask

    // Memory op (or plain op when mem=0) in EX for one cycle, then a bubble;
    // the decode instruction is held while the stall length is counted.
    task automatic measure(input string name, input logic mem, input logic [AW-1:0] rd,
                           input logic pop, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                           input logic [1:0] used, input logic jmp,
                           input int exp_n, input int exp_slot);
        int n;
        settle();
        ex_valid = 1; ex_mem_read = mem; ex_pop = pop; ex_rd = rd;
        dec_valid = 1; dec_rs = {rs1, rs0}; dec_rs_used = used; dec_jmp = jmp;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (k == 0) check({name, "_slot"}, int'(hazard_slot), exp_slot);
            if (!stall) break;
            n++;
            tick();
            ex_valid = 0; ex_mem_read = 0; ex_pop = 0;
        end
        check({name, "_len"}, n, exp_n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        rst_n = 0;
        #1;
        check("reset_stall", int'(stall), 0);
        check("reset_count", int'(stall_count), 0);
        tick(); tick();
        rst_n = 1;
        tick();

        measure("load_fwd",  1, 3'd3, 0, 3'd3, 3'd7, 2'b01, 0, LL, 1);
        measure("pop_jmp",   1, 3'd5, 1, 3'd5, 3'd7, 2'b00, 1, LL + PJE, 1);
        measure("pop_ord",   1, 3'd5, 1, 3'd5, 3'd7, 2'b01, 0, LL, 1);
        measure("no_dep",    1, 3'd2, 0, 3'd4, 3'd6, 2'b11, 0, 0, 0);
        measure("reg0",      1, 3'd0, 0, 3'd0, 3'd7, 2'b01, 0, LL, 1);
        measure("slot1",     1, 3'd6, 0, 3'd1, 3'd6, 2'b11, 0, LL, 2);
        measure("non_mem",   0, 3'd3, 0, 3'd3, 3'd3, 2'b11, 1, 0, 0);

        // Flush right after a pop: no stall in the flush cycle nor afterwards.
        settle();
        ex_valid = 1; ex_mem_read = 1; ex_pop = 1; ex_rd = 3'd5;
        tick();
        set_idle();
        flush = 1; dec_valid = 1; dec_rs = {3'd7, 3'd5}; dec_jmp = 1;
        #2 check("flush_now", int'(stall), 0);
        tick(); flush = 0;
        #2 check("flush_after1", int'(stall), 0);
        tick();
        #2 check("flush_after2", int'(stall), 0);

        // Reset pulse in the middle of a jump stall.
        settle();
        ex_valid = 1; ex_mem_read = 1; ex_pop = 1; ex_rd = 3'd5;
        dec_valid = 1; dec_rs = {3'd7, 3'd5}; dec_jmp = 1;
        #2 check("rst_pre0", int'(stall), 1);
        tick(); ex_valid = 0; ex_mem_read = 0; ex_pop = 0;
        #2 check("rst_pre1", int'(stall), 1);
        #1 rst_n = 0;
        #1;
        check("rst_async_stall", int'(stall), 0);
        check("rst_async_slot", int'(hazard_slot), 0);
        check("rst_async_count", int'(stall_count), 0);
        tick(); tick();
        rst_n = 1;
        #2 check("rst_release", int'(stall), 0);
        tick();
        #2 check("rst_release2", int'(stall), 0);

        measure("perf_load", 1, 3'd1, 0, 3'd1, 3'd7, 2'b01, 0, LL, 1);
`ifdef HDU_PERF_EN
        check("perf_count", int'(stall_count), LL);
`else
        check("perf_count", int'(stall_count), 0);
`endif

        // Randomized traffic checked by the per-cycle model comparison.
        set_idle();
        for (int c = 0; c < 4000; c++) begin
            tick();
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_pop      = $urandom_range(0, 1) == 1;
            ex_rd       = AW'($urandom_range(0, NR - 1));
            dec_valid   = ($urandom_range(0, 4) != 0);
            dec_rs      = (NS*AW)'($urandom);
            dec_rs_used = NS'($urandom);
            dec_jmp     = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 15) == 0);
        end
        tick();
        set_idle();
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 3, register-address width; register file holds 2**REG_ADDR_W entries.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of decode source-operand slots; slot 0 doubles as the jump-target slot.
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..7, cycles from a load leaving EX until its data is forwardable.
REQ-004 SHALL have parameter POP_JMP_EXTRA, default 1, range 0..7, extra cycles a popped value needs before a jump may consume it.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 dec_valid  input  1  decode stage holds a valid instruction.
REQ-008 dec_rs  input  NUM_SRC*REG_ADDR_W  packed source register addresses; slot i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-009 dec_rs_used  input  NUM_SRC  per-slot "operand is read" flag.
REQ-010 dec_jmp  input  1  decode instruction is a register jump that consumes slot 0.
REQ-011 ex_valid  input  1  execute stage holds a valid instruction.
REQ-012 ex_mem_read  input  1  execute instruction reads memory (load or pop).
REQ-013 ex_pop  input  1  execute memory read is a pop.
REQ-014 ex_rd  input  REG_ADDR_W  execute destination register.
REQ-015 flush  input  1  pipeline flush; kills decode and all in-flight loads.
REQ-016 stall  output  1  freeze PC and IF/ID register.
REQ-017 bubble_sel  output  1  select NOP into ID/EX; always equal to stall.
REQ-018 hazard_slot  output  NUM_SRC  one-hot-or-more mask of slots causing the current stall.
REQ-019 stall_count  output  16  saturating count of stall cycles (see Configuration).

Function
REQ-020 The block SHALL keep, per register r, two down-counters fwd_cnt[r] and jmp_cnt[r], each 4 bits wide.
REQ-021 An issue event SHALL occur when ex_valid & ex_mem_read & !flush in a cycle.
REQ-022 On an issue event, the block SHALL load fwd_cnt[ex_rd] <= LOAD_LAT-1 and jmp_cnt[ex_rd] <= LOAD_LAT-1 (+POP_JMP_EXTRA if ex_pop).
REQ-023 On every other cycle, each nonzero counter SHALL decrement by 1, saturating at 0; decrementing continues while stall is high.
REQ-024 When issue and decrement target the same register in one cycle, issue SHALL win.
REQ-025 Slot i ordinary hazard SHALL be: dec_rs_used[i] & (issue event & ex_rd==rs_i | fwd_cnt[rs_i]!=0).
REQ-026 Slot 0 jump hazard, when dec_jmp, SHALL be: issue event & ex_rd==rs_0 | jmp_cnt[rs_0]!=0, regardless of dec_rs_used[0].
REQ-027 stall SHALL be combinational: dec_valid & !flush & OR of all slot hazards; hazard_slot SHALL report per-slot hazards under the same qualification.
REQ-028 Register 0 SHALL be tracked like any other register (no hardwired zero).
REQ-029 flush SHALL force stall=0 in the same cycle and clear all counters at the next edge.
REQ-030 A non-memory instruction in EX SHALL neither create nor clear scoreboard entries.

Reset
REQ-031 While rst_n=0, all counters SHALL be 0, stall_count SHALL be 0, and stall, bubble_sel, and hazard_slot SHALL be 0 with no clock edge required.
REQ-032 Reset deasserted mid-stall SHALL leave the block with no pending hazards; the first edge after release SHALL behave as a normal cycle.

Configuration
REQ-033 With macro HDU_PERF_EN defined, stall_count SHALL increment on every clock edge with stall=1, saturate at 16'hFFFF, and clear on flush-free reset only.
REQ-034 Without HDU_PERF_EN, stall_count SHALL be tied to 0 and no counter register SHALL be synthesised.

Structure
REQ-035 Package hdu_pkg SHALL hold the REG_ADDR_W default, the 4-bit counter typedef, and the LOAD_LAT/POP_JMP_EXTRA defaults.
REQ-036 A sub-module sb_entry (one fwd/jmp counter pair with issue, decrement, and clear) SHALL be instantiated 2**REG_ADDR_W times.

Verification (defaults unless stated)
REQ-037 Load R3 in EX, decode rs0=R3 used -> stall=1 for exactly 1 cycle, hazard_slot=2'b01, then stall=0.
REQ-038 Pop R5 in EX, decode jmp via rs0=R5 -> stall for 2 cycles; the same pop with an ordinary use of R5 -> stall for 1 cycle.
REQ-039 Load R2 in EX, decode using R4/R6 -> stall=0 throughout.
REQ-040 Pop R5, then flush in the next cycle with decode jmp R5 -> stall=0 immediately and no stall afterwards.
REQ-041 rst_n pulsed low mid-stall -> stall drops to 0 asynchronously; with HDU_PERF_EN defined, stall_count reads 0.
REQ-042 LOAD_LAT=3, load R1 then consumer of R1 -> 3 stall cycles; with HDU_PERF_EN defined, stall_count=3.
